// File: rtl/i2c_slave_regs.sv
// I2C target with a 16 x 8 register file, sampled directly on the system clock.
// Supports pointer writes, auto-incrementing burst writes and reads, and a local read port.
module i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       scl,
    inout  wire        sda,
    input  logic [3:0] reg_rd_addr,
    output logic [7:0] reg_rd_data,
    output logic       wr_valid,
    output logic [3:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic [3:0] state_reg
);

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_ADDR     = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK = 4'd2;
    localparam logic [3:0] ST_PTR      = 4'd3;
    localparam logic [3:0] ST_PTR_ACK  = 4'd4;
    localparam logic [3:0] ST_WR_DATA  = 4'd5;
    localparam logic [3:0] ST_WR_ACK   = 4'd6;
    localparam logic [3:0] ST_RD_DATA  = 4'd7;
    localparam logic [3:0] ST_RD_ACK   = 4'd8;

    logic [7:0] regs [16];
    logic [3:0] state;
    logic [3:0] ptr;
    logic [2:0] bit_cnt;
    logic       rw;
    logic       sda_low;
    logic       scl_q;
    logic       sda_q;
    logic [6:0] rx_shift;
    logic [6:0] tx_shift;

    logic       sda_in;
    logic       rise;
    logic       start_det;
    logic       stop_det;
    logic       last_bit;
    logic [7:0] rx_next;

    assign sda       = sda_low ? 1'b0 : 1'bz;
    assign sda_in    = sda;
    assign rise      = !scl_q && scl;
    assign start_det = scl_q && scl && sda_q && !sda_in;
    assign stop_det  = scl_q && scl && !sda_q && sda_in;
    assign last_bit  = (bit_cnt == 3'd7);
    assign rx_next   = {rx_shift, sda_in};

    assign reg_rd_data = regs[reg_rd_addr];
    assign busy        = (state != ST_IDLE);
    assign state_reg   = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 8'h00;
            end
            state    <= ST_IDLE;
            ptr      <= 4'd0;
            bit_cnt  <= 3'd0;
            rw       <= 1'b0;
            sda_low  <= 1'b0;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            wr_valid <= 1'b0;
            wr_addr  <= 4'd0;
            wr_data  <= 8'h00;
        end else begin
            scl_q    <= scl;
            sda_q    <= sda_in;
            wr_valid <= 1'b0;
            // Bus conditions outrank any rise seen in the same cycle
            if (start_det) begin
                state   <= ST_ADDR;
                bit_cnt <= 3'd0;
                sda_low <= 1'b0;
            end else if (stop_det) begin
                state   <= ST_IDLE;
                bit_cnt <= 3'd0;
                sda_low <= 1'b0;
            end else if (rise) begin
                case (state)
                    ST_ADDR: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            if (rx_next[7:1] == SLAVE_ADDR) begin
                                rw      <= rx_next[0];
                                sda_low <= 1'b1;
                                state   <= ST_ADDR_ACK;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (!rw) begin
                            sda_low <= 1'b0;
                            state   <= ST_PTR;
                        end else begin
                            sda_low <= !regs[ptr][7];
                            state   <= ST_RD_DATA;
                        end
                    end
                    ST_PTR: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            ptr     <= rx_next[3:0];
                            sda_low <= 1'b1;
                            state   <= ST_PTR_ACK;
                        end
                    end
                    ST_PTR_ACK: begin
                        sda_low <= 1'b0;
                        state   <= ST_WR_DATA;
                    end
                    ST_WR_DATA: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            regs[ptr] <= rx_next;
                            wr_valid  <= 1'b1;
                            wr_addr   <= ptr;
                            wr_data   <= rx_next;
                            ptr       <= ptr + 4'd1;
                            sda_low   <= 1'b1;
                            state     <= ST_WR_ACK;
                        end
                    end
                    ST_WR_ACK: begin
                        sda_low <= 1'b0;
                        state   <= ST_WR_DATA;
                    end
                    ST_RD_DATA: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            sda_low <= 1'b0;
                            ptr     <= ptr + 4'd1;
                            state   <= ST_RD_ACK;
                        end else begin
                            sda_low <= !tx_shift[6];
                        end
                    end
                    ST_RD_ACK: begin
                        // Master ACK continues the burst from the already-advanced pointer
                        if (!sda_in) begin
                            sda_low <= !regs[ptr][7];
                            state   <= ST_RD_DATA;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // tx_shift holds the bits still to send below the one currently on SDA
    always_ff @(posedge clk) begin
        if (rise) begin
            rx_shift <= rx_next[6:0];
        end
        if (rise && !start_det && !stop_det) begin
            if (state == ST_ADDR_ACK && rw) begin
                tx_shift <= regs[ptr][6:0];
            end else if (state == ST_RD_DATA) begin
                tx_shift <= {tx_shift[5:0], 1'b0};
            end else if (state == ST_RD_ACK && !sda_in) begin
                tx_shift <= regs[ptr][6:0];
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: a bit-level I2C master drives scl/sda
// against hand-computed expectations for writes, wrap, reads, NACK, abort and reset.
module tb_i2c_slave_regs;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic [3:0] reg_rd_addr = 4'd0;
    logic [7:0] reg_rd_data;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic [3:0] state_reg;
    wire        sda;

    int checks = 0;
    int failures = 0;

    logic [3:0] wa_q [$];
    logic [7:0] wd_q [$];

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave_regs #(.SLAVE_ADDR(7'h50)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .scl        (scl),
        .sda        (sda),
        .reg_rd_addr(reg_rd_addr),
        .reg_rd_data(reg_rd_data),
        .wr_valid   (wr_valid),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .state_reg  (state_reg)
    );

    always @(negedge clk) begin
        if (wr_valid) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One SCL clock: data set in low phase, sampled at start of high phase, SCL high across one edge
    task automatic master_bit(input logic b, output logic s);
        @(negedge clk) m_low = !b;
        @(negedge clk) scl = 1'b1;
        #1 s = sda;
        @(negedge clk) scl = 1'b0;
    endtask

    task automatic start_cond();
        @(negedge clk) begin m_low = 1'b0; scl = 1'b1; end
        @(negedge clk);
        @(negedge clk) m_low = 1'b1;
        @(negedge clk) scl = 1'b0;
    endtask

    task automatic stop_cond();
        @(negedge clk) m_low = 1'b1;
        @(negedge clk) scl = 1'b1;
        @(negedge clk) m_low = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) master_bit(b[i], s);
        master_bit(1'b1, ack);
    endtask

    task automatic recv_bits(input int n, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < n; i++) begin
            master_bit(1'b1, s);
            d = {d[6:0], s};
        end
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a, input logic [7:0] exp);
        reg_rd_addr = a;
        #1 check(tag, reg_rd_data, exp);
    endtask

    task automatic check_log(input int n, input logic [3:0] a0, input logic [7:0] d0,
                             input logic [3:0] a1, input logic [7:0] d1);
        check("wr_cnt", wa_q.size(), n);
        for (int i = 0; i < n && i < wa_q.size(); i++) begin
            check("wr_addr", wa_q[i], (i == 0) ? a0 : a1);
            check("wr_data", wd_q[i], (i == 0) ? d0 : d1);
        end
        wa_q.delete();
        wd_q.delete();
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_state", state_reg, 4'd0);
        check("rst_wr_valid", wr_valid, 1'b0);
        check("rst_sda", sda, 1'b1);
        check_reg("rst_reg5", 4'd5, 8'h00);
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write ptr 3, data A5 then 3C
        start_cond();
        send_byte(8'hA0, ack); check("w_addr_ack", ack, 1'b0);
        check("w_busy", busy, 1'b1);
        send_byte(8'h03, ack); check("w_ptr_ack", ack, 1'b0);
        send_byte(8'hA5, ack); check("w_d0_ack", ack, 1'b0);
        send_byte(8'h3C, ack); check("w_d1_ack", ack, 1'b0);
        stop_cond();
        check_log(2, 4'd3, 8'hA5, 4'd4, 8'h3C);
        check_reg("w_reg3", 4'd3, 8'hA5);
        check_reg("w_reg4", 4'd4, 8'h3C);
        check("w_busy_end", busy, 1'b0);

        // Pointer wrap 15 -> 0
        start_cond();
        send_byte(8'hA0, ack);
        send_byte(8'h0F, ack);
        send_byte(8'h11, ack); check("wrap_ack0", ack, 1'b0);
        send_byte(8'h22, ack); check("wrap_ack1", ack, 1'b0);
        stop_cond();
        check_log(2, 4'hF, 8'h11, 4'h0, 8'h22);
        check_reg("wrap_reg15", 4'd15, 8'h11);
        check_reg("wrap_reg0", 4'd0, 8'h22);
        check("wrap_ptr", dut.ptr, 4'd1);

        // Read back reg 3 with master NACK
        start_cond();
        send_byte(8'hA0, ack);
        send_byte(8'h03, ack);
        stop_cond();
        start_cond();
        send_byte(8'hA1, ack); check("r_addr_ack", ack, 1'b0);
        recv_bits(8, d);
        check("r_data", d, 8'hA5);
        master_bit(1'b1, ack);
        check("r_nack_rel", ack, 1'b1);
        check("r_ptr", dut.ptr, 4'd4);
        check("r_state", state_reg, 4'd0);
        stop_cond();
        check_log(0, 4'd0, 8'h00, 4'd0, 8'h00);

        // Address 0x51 is not ours
        start_cond();
        begin
            logic s;
            for (int i = 7; i >= 0; i--) master_bit(logic'(8'hA2 >> i), s);
        end
        check("na_busy", busy, 1'b0);
        master_bit(1'b1, ack);
        check("na_ack", ack, 1'b1);
        send_byte(8'h77, ack);
        stop_cond();
        check_log(0, 4'd0, 8'h00, 4'd0, 8'h00);
        check_reg("na_reg4", 4'd4, 8'h3C);
        check_reg("na_reg7", 4'd7, 8'h00);

        // Abort a data byte after four bits
        start_cond();
        send_byte(8'hA0, ack);
        send_byte(8'h02, ack);
        begin
            logic s;
            master_bit(1'b1, s); master_bit(1'b0, s);
            master_bit(1'b1, s); master_bit(1'b1, s);
        end
        stop_cond();
        check_log(0, 4'd0, 8'h00, 4'd0, 8'h00);
        check_reg("ab_reg2", 4'd2, 8'h00);
        check("ab_state", state_reg, 4'd0);
        check("ab_sda", sda, 1'b1);

        // Reset in the middle of a read while the slave holds SDA low
        start_cond();
        send_byte(8'hA0, ack);
        send_byte(8'h03, ack);
        stop_cond();
        start_cond();
        send_byte(8'hA1, ack);
        recv_bits(4, d);
        check("rr_bits", d, 8'h0A);
        check("rr_sda_low", sda, 1'b0);
        #2 reset_n = 1'b0;
        #1 check("rr_sda_rel", sda, 1'b1);
        scl = 1'b1;
        m_low = 1'b0;
        @(negedge clk);
        check("rr_busy", busy, 1'b0);
        check("rr_state", state_reg, 4'd0);
        check("rr_wr_valid", wr_valid, 1'b0);
        check("rr_wr_addr", wr_addr, 4'd0);
        check("rr_wr_data", wr_data, 8'h00);
        check("rr_ptr", dut.ptr, 4'd0);
        for (int i = 0; i < 16; i++) check_reg("rr_reg", 4'(i), 8'h00);
        @(negedge clk) reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
